mem_arbiter: RTL and testbench

Two-master, single-port memory arbiter that shares one valid/ready memory interface between the CPU instruction-fetch channel and the CPU load/store channel. It sits between the multi-cycle RISC-V core and the unified memory/bus bridge. It serialises requests with one transaction outstanding at a time and routes each read response back to the master that issued it. It also exports a grant-conflict performance counter.

---
 rtl/mem_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one valid/ready memory port between the CPU instruction-fetch channel
// (INST) and the load/store channel (DATA). Only one transaction is in flight
// at a time. Each read response is routed back to the master that issued the
// request.
//
// Build option:
//   MEM_ARB_RR_EN  defined   : round-robin on a conflict. The master that was
//                              not granted last wins.
//                  undefined : fixed priority. DATA always wins a conflict.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset (0 = reset)
//   inst_addr/_req_valid  fetch request          -> inst_req_ready
//   inst_rdata/_rvalid    fetch response         <- inst_rready
//   data_addr/_wen/_ren   load/store request     -> data_req_ready
//   data_wdata/_wstrb     store payload
//   data_rdata/_rvalid    load response          <- data_rready
//   mem_addr/_wen/_ren    memory request         <- mem_req_ready
//   mem_wdata/_wstrb      memory store payload
//   mem_rdata/_rvalid     memory read response   -> mem_rready
//   conflict_cnt          IDLE cycles in which both masters were requesting
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic                inst_req_valid,
    output logic                inst_req_ready,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_rvalid,
    input  logic                inst_rready,

    input  logic [ADDR_W-1:0]   data_addr,
    input  logic                data_wen,
    input  logic                data_ren,
    input  logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W/8-1:0] data_wstrb,
    output logic                data_req_ready,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_rvalid,
    input  logic                data_rready,

    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic                mem_ren,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_req_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_rvalid,
    output logic                mem_rready,

    output logic [31:0]         conflict_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    state_t state, state_nxt;
    owner_t owner, owner_nxt;
    owner_t last_grant, last_grant_nxt;
    logic   is_read, is_read_nxt;
    logic   cnt_inc;

    logic   inst_req;
    logic   data_req;
    owner_t conflict_winner;
    logic   resp_fire;

    assign inst_req = inst_req_valid;
    // A load/store with both enables set is treated as a store.
    assign data_req = data_wen | data_ren;

`ifdef MEM_ARB_RR_EN
    assign conflict_winner = (last_grant == OWN_INST) ? OWN_DATA : OWN_INST;
`else
    assign conflict_winner = OWN_DATA;
`endif

    // The response handshake, seen from the owner's side.
    assign resp_fire = mem_rvalid & ((owner == OWN_INST) ? inst_rready : data_rready);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge, whatever the order of the
    // statements.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            owner        <= OWN_INST;
            last_grant   <= OWN_DATA;
            is_read      <= 1'b0;
            conflict_cnt <= 32'd0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            is_read    <= is_read_nxt;
            if (cnt_inc) begin
                conflict_cnt <= conflict_cnt + 32'd1;   // wraps to 0
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the combinational
    // block, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        is_read_nxt    = is_read;
        cnt_inc        = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (inst_req || data_req) begin
                    if (inst_req && data_req) begin
                        owner_nxt = conflict_winner;
                        cnt_inc   = 1'b1;
                    end else if (inst_req) begin
                        owner_nxt = OWN_INST;
                    end else begin
                        owner_nxt = OWN_DATA;
                    end
                    is_read_nxt = (owner_nxt == OWN_INST) || !data_wen;
                    state_nxt   = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    last_grant_nxt = owner;
                    state_nxt      = is_read ? S_RESP : S_IDLE;
                end
            end
            S_RESP: begin
                if (resp_fire) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: request and response paths are pure muxes on the owner. This
    // gives zero-latency passthrough in both directions.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_addr       = '0;
        mem_wen        = 1'b0;
        mem_ren        = 1'b0;
        mem_wdata      = '0;
        mem_wstrb      = '0;
        mem_rready     = 1'b0;
        inst_req_ready = 1'b0;
        inst_rvalid    = 1'b0;
        inst_rdata     = '0;
        data_req_ready = 1'b0;
        data_rvalid    = 1'b0;
        data_rdata     = '0;

        case (state)
            S_REQ: begin
                mem_ren = is_read;
                mem_wen = !is_read;
                if (owner == OWN_INST) begin
                    mem_addr       = inst_addr;
                    inst_req_ready = mem_req_ready;
                end else begin
                    mem_addr       = data_addr;
                    mem_wdata      = data_wdata;
                    mem_wstrb      = data_wstrb;
                    data_req_ready = mem_req_ready;
                end
            end
            S_RESP: begin
                if (owner == OWN_INST) begin
                    inst_rvalid = mem_rvalid;
                    inst_rdata  = mem_rdata;
                    mem_rready  = inst_rready;
                end else begin
                    data_rvalid = mem_rvalid;
                    data_rdata  = mem_rdata;
                    mem_rready  = data_rready;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Scoreboard bench for mem_arbiter. The stimulus pushes the expected memory
// requests and read responses into queues. A negedge monitor pops an entry at
// every request or response handshake and compares it. A tiny memory model
// returns rdata = (address of the last accepted read) ^ RD_KEY. With this key,
// address 0x100 reads back as 0x00500093.
// The conflict-order expectations follow MEM_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int          ADDR_W = 32;
    localparam int          DATA_W = 32;
    localparam logic [31:0] RD_KEY = 32'h0050_0193;

    logic               clk = 1'b0;
    logic               rst;
    logic [ADDR_W-1:0]  inst_addr;
    logic               inst_req_valid;
    logic               inst_req_ready;
    logic [DATA_W-1:0]  inst_rdata;
    logic               inst_rvalid;
    logic               inst_rready;
    logic [ADDR_W-1:0]  data_addr;
    logic               data_wen;
    logic               data_ren;
    logic [DATA_W-1:0]  data_wdata;
    logic [3:0]         data_wstrb;
    logic               data_req_ready;
    logic [DATA_W-1:0]  data_rdata;
    logic               data_rvalid;
    logic               data_rready;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_wen;
    logic               mem_ren;
    logic [DATA_W-1:0]  mem_wdata;
    logic [3:0]         mem_wstrb;
    logic               mem_req_ready;
    logic [DATA_W-1:0]  mem_rdata;
    logic               mem_rvalid;
    logic               mem_rready;
    logic [31:0]        conflict_cnt;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_addr      (inst_addr),
        .inst_req_valid (inst_req_valid),
        .inst_req_ready (inst_req_ready),
        .inst_rdata     (inst_rdata),
        .inst_rvalid    (inst_rvalid),
        .inst_rready    (inst_rready),
        .data_addr      (data_addr),
        .data_wen       (data_wen),
        .data_ren       (data_ren),
        .data_wdata     (data_wdata),
        .data_wstrb     (data_wstrb),
        .data_req_ready (data_req_ready),
        .data_rdata     (data_rdata),
        .data_rvalid    (data_rvalid),
        .data_rready    (data_rready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_ren        (mem_ren),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_req_ready  (mem_req_ready),
        .mem_rdata      (mem_rdata),
        .mem_rvalid     (mem_rvalid),
        .mem_rready     (mem_rready),
        .conflict_cnt   (conflict_cnt)
    );

    always #5 clk = ~clk;

    // Memory model: remember the address of each accepted read.
    logic [31:0] lat_addr = 32'd0;
    always @(negedge clk) begin
        if (mem_ren && mem_req_ready) lat_addr <= mem_addr;
    end
    assign mem_rdata = lat_addr ^ RD_KEY;

    typedef struct packed {
        logic        is_data;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct packed {
        logic        is_data;
        logic [31:0] rdata;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic d, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] s);
        req_t e;
        e.is_data = d; e.wen = w; e.addr = a; e.wdata = wd; e.wstrb = s;
        req_q.push_back(e);
    endtask

    task automatic push_rsp(input logic d, input logic [31:0] rd);
        rsp_t r;
        r.is_data = d; r.rdata = rd;
        rsp_q.push_back(r);
    endtask

    function automatic logic [11:0] out_bits();
        return {inst_req_ready, inst_rvalid, |inst_rdata, data_req_ready, data_rvalid,
                |data_rdata, |mem_addr, mem_wen, mem_ren, |mem_wdata, |mem_wstrb, mem_rready};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the request handshake of one master, then step past it.
    task automatic wait_accept(input logic is_data, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (is_data ? data_req_ready : inst_req_ready) seen = 1'b1;
        end
        check(name, seen, 1'b1);
        tick();
    endtask

    // -------------------------------------------------------------------------
    // Monitor / scoreboard
    // -------------------------------------------------------------------------
    initial begin : monitor
        req_t e;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst && mem_req_ready && (mem_ren || mem_wen)) begin
                if (req_q.size() == 0) begin
                    check("unexpected_req", {mem_wen, mem_addr}, 0);
                end else begin
                    e = req_q.pop_front();
                    check("req_master", {data_req_ready, inst_req_ready}, e.is_data ? 2'b10 : 2'b01);
                    check("req_wen_ren", {mem_wen, mem_ren}, e.wen ? 2'b10 : 2'b01);
                    check("req_addr", mem_addr, e.addr);
                    if (e.wen) begin
                        check("req_wdata", mem_wdata, e.wdata);
                        check("req_wstrb", mem_wstrb, e.wstrb);
                    end
                end
            end
            if (rst && inst_rvalid && inst_rready) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_inst_rsp", inst_rdata, 0);
                end else begin
                    r = rsp_q.pop_front();
                    check("inst_rsp_owner", 1'b0, r.is_data);
                    check("inst_rdata", inst_rdata, r.rdata);
                    check("inst_rsp_other_quiet", {data_rvalid, data_rdata}, 0);
                end
            end
            if (rst && data_rvalid && data_rready) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_data_rsp", data_rdata, 0);
                end else begin
                    r = rsp_q.pop_front();
                    check("data_rsp_owner", 1'b1, r.is_data);
                    check("data_rdata", data_rdata, r.rdata);
                    check("data_rsp_other_quiet", {inst_rvalid, inst_rdata}, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin : stimulus
        int grants;
        int inst_seen;

        rst            = 1'b0;
        inst_addr      = 32'h100;
        inst_req_valid = 1'b1;
        inst_rready    = 1'b1;
        data_addr      = 32'h200;
        data_wen       = 1'b1;
        data_ren       = 1'b0;
        data_wdata     = 32'hFFFF_FFFF;
        data_wstrb     = 4'hF;
        data_rready    = 1'b1;
        mem_req_ready  = 1'b1;
        mem_rvalid     = 1'b1;

        // Reset with active inputs: every output stays quiet.
        #3;
        check("reset_outputs", out_bits(), 12'd0);
        check("reset_cnt", conflict_cnt, 32'd0);
        tick();
        inst_req_valid = 1'b0;
        data_wen       = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_idle", out_bits(), 12'd0);

        // Single fetch: IDLE, REQ, RESP.
        push_req(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
        push_rsp(1'b0, 32'h0050_0093);
        tick();
        inst_addr      = 32'h100;
        inst_req_valid = 1'b1;
        @(negedge clk);
        check("fetch_idle_no_req", mem_ren, 1'b0);
        tick();
        @(negedge clk);
        check("fetch_req_cycle", {mem_ren, mem_addr, inst_req_ready}, {1'b1, 32'h100, 1'b1});
        tick();
        inst_req_valid = 1'b0;
        @(negedge clk);
        check("fetch_resp_cycle", {inst_rvalid, inst_rdata}, {1'b1, 32'h0050_0093});
        check("fetch_data_quiet", data_rvalid, 1'b0);
        tick();
        @(negedge clk);
        check("fetch_back_idle", {inst_rvalid, mem_ren, mem_rready}, 3'b000);

        // Store: two cycles, no response on either master.
        push_req(1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'h3);
        tick();
        data_addr  = 32'h200;
        data_wen   = 1'b1;
        data_wdata = 32'hDEAD_BEEF;
        data_wstrb = 4'h3;
        @(negedge clk);
        check("store_idle_no_req", mem_wen, 1'b0);
        tick();
        @(negedge clk);
        check("store_req_cycle", {data_req_ready, mem_wen, mem_ren}, 3'b110);
        tick();
        data_wen = 1'b0;
        @(negedge clk);
        check("store_back_idle", {data_req_ready, mem_wen, data_rvalid, inst_rvalid, mem_rready}, 5'd0);
        check("cnt_no_conflict", conflict_cnt, 32'd0);

        // Continuous conflict; the DATA side asserts both enables (a write).
`ifdef MEM_ARB_RR_EN
        push_req(1'b0, 1'b0, 32'h300, 32'h0, 4'h0);
        push_rsp(1'b0, 32'h0050_0293);
        push_req(1'b1, 1'b1, 32'h400, 32'h1234_5678, 4'hF);
        push_req(1'b0, 1'b0, 32'h300, 32'h0, 4'h0);
        push_rsp(1'b0, 32'h0050_0293);
`else
        push_req(1'b1, 1'b1, 32'h400, 32'h1234_5678, 4'hF);
        push_req(1'b1, 1'b1, 32'h400, 32'h1234_5678, 4'hF);
        push_req(1'b1, 1'b1, 32'h400, 32'h1234_5678, 4'hF);
`endif
        tick();
        inst_addr      = 32'h300;
        inst_req_valid = 1'b1;
        data_addr      = 32'h400;
        data_wen       = 1'b1;
        data_ren       = 1'b1;
        data_wdata     = 32'h1234_5678;
        data_wstrb     = 4'hF;
        grants    = 0;
        inst_seen = 0;
        for (int i = 0; i < 40 && grants < 3; i++) begin
            @(negedge clk);
            if (inst_req_ready) inst_seen++;
            if (mem_req_ready && (mem_ren || mem_wen)) grants++;
        end
        check("conflict_grants", grants, 3);
        tick();
        inst_req_valid = 1'b0;
        data_wen       = 1'b0;
        data_ren       = 1'b0;
`ifdef MEM_ARB_RR_EN
        check("rr_inst_granted", inst_seen, 2);
`else
        check("fixed_inst_starved", inst_seen, 0);
`endif
        tick();
        tick();
        @(negedge clk);
        check("conflict_cnt_3", conflict_cnt, 32'd3);

        // Backpressure: request stall, then response stall.
        push_req(1'b0, 1'b0, 32'h104, 32'h0, 4'h0);
        push_rsp(1'b0, 32'h0050_0097);
        tick();
        mem_req_ready  = 1'b0;
        inst_rready    = 1'b0;
        inst_addr      = 32'h104;
        inst_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            check("bp_req_hold", {mem_ren, mem_addr, inst_req_ready}, {1'b1, 32'h104, 1'b0});
        end
        tick();
        mem_req_ready = 1'b1;
        tick();
        inst_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_rready_low", {mem_rready, inst_rvalid}, 2'b01);
            tick();
        end
        inst_rready = 1'b1;
        @(negedge clk);
        check("bp_resp_fire", {mem_rready, inst_rvalid}, 2'b11);
        tick();
        @(negedge clk);
        check("bp_back_idle", {inst_rvalid, mem_rready, mem_ren}, 3'b000);

        // Reset while waiting in RESP abandons the fetch.
        push_req(1'b0, 1'b0, 32'h10C, 32'h0, 4'h0);
        tick();
        mem_rvalid     = 1'b0;
        inst_addr      = 32'h10C;
        inst_req_valid = 1'b1;
        tick();
        tick();
        inst_req_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_in_resp", {mem_rready, inst_rvalid}, 2'b10);
        #2;
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        #1;
        check("rst_mid_outputs", out_bits(), 12'd0);
        check("rst_mid_cnt", conflict_cnt, 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("rst_late_rvalid_ignored", out_bits(), 12'd0);

        // A fresh fetch completes normally.
        push_req(1'b0, 1'b0, 32'h108, 32'h0, 4'h0);
        push_rsp(1'b0, 32'h0050_009B);
        tick();
        inst_addr      = 32'h108;
        inst_req_valid = 1'b1;
        wait_accept(1'b0, "fresh_fetch_accept");
        inst_req_valid = 1'b0;
        repeat (3) tick();

        check("req_queue_drained", req_q.size(), 0);
        check("rsp_queue_drained", rsp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
